// File: rtl/fetch_unit.sv
// LEGv8 instruction-fetch front end: PC, imem req/ack handshake, one-entry skid, IF/ID outputs.
// Optional macro FETCH_ALIGN_CHECK_EN: a misaligned redirect raises a sticky fetch_fault and parks in FAULT.
module fetch_unit #(
  parameter int            N        = 64,
  parameter logic [N-1:0]  RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          redirect,
  input  logic [N-1:0]  redirect_pc,
  output logic          imem_req,
  output logic [N-1:0]  imem_addr,
  input  logic          imem_ack,
  input  logic [31:0]   imem_rdata,
  output logic          if_valid,
  output logic [N-1:0]  if_pc,
  output logic [31:0]   if_instr,
  output logic          fetch_fault
);

`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic [1:0] {IDLE, REQ, HOLD, FAULT} state_t;
`else
  typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;
`endif

  state_t        state, state_n;
  logic [N-1:0]  pc, pc_n;
  logic [N-1:0]  addr, addr_n;
  logic          valid_n;
  logic [N-1:0]  ifpc_n;
  logic [31:0]   instr_n;
  logic          skid_vld, skid_vld_n;
  logic [N-1:0]  skid_pc, skid_pc_n;
  logic [31:0]   skid_instr, skid_instr_n;
  logic          discard, discard_n;
  logic          fault, fault_n;
  logic          fault_pend, fault_pend_n;
  logic          accept;
  logic          misalign;
  logic [N-1:0]  rpc;
  logic [N-1:0]  addr_inc;

  assign accept   = !if_valid || !stall;
  assign addr_inc = addr + N'(4);

`ifdef FETCH_ALIGN_CHECK_EN
  assign rpc      = redirect_pc;
  assign misalign = redirect_pc[1:0] != 2'b00;
`else
  assign rpc      = {redirect_pc[N-1:2], 2'b00};
  assign misalign = 1'b0;
`endif

  assign imem_req    = (state == REQ);
  assign imem_addr   = addr;
  assign fetch_fault = fault;

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    addr_n       = addr;
    valid_n      = if_valid;
    ifpc_n       = if_pc;
    instr_n      = if_instr;
    skid_vld_n   = skid_vld;
    skid_pc_n    = skid_pc;
    skid_instr_n = skid_instr;
    discard_n    = discard;
    fault_n      = fault;
    fault_pend_n = fault_pend;

    // The presented instruction is consumed whenever decode is not stalled.
    if (if_valid && !stall) valid_n = 1'b0;

`ifdef FETCH_ALIGN_CHECK_EN
    if (state == FAULT) begin
      valid_n = 1'b0;
    end else
`endif
    if (redirect && !fault_pend) begin
      valid_n    = 1'b0;
      skid_vld_n = 1'b0;
      pc_n       = rpc;
      if (misalign) fault_n = 1'b1;
      if (state == REQ && !imem_ack) begin
        // Request in flight cannot be withdrawn: drop its data when it lands.
        discard_n    = 1'b1;
        fault_pend_n = misalign;
      end else begin
        addr_n    = rpc;
        discard_n = 1'b0;
        state_n   = REQ;
`ifdef FETCH_ALIGN_CHECK_EN
        if (misalign) state_n = FAULT;
`endif
      end
    end else begin
      case (state)
        IDLE: state_n = REQ;
        REQ: begin
          if (imem_ack) begin
            if (discard) begin
              discard_n = 1'b0;
              addr_n    = pc;
`ifdef FETCH_ALIGN_CHECK_EN
              if (fault_pend) begin
                fault_pend_n = 1'b0;
                state_n      = FAULT;
              end
`endif
            end else if (accept) begin
              valid_n = 1'b1;
              ifpc_n  = addr;
              instr_n = imem_rdata;
              pc_n    = addr_inc;
              addr_n  = addr_inc;
            end else begin
              skid_vld_n   = 1'b1;
              skid_pc_n    = addr;
              skid_instr_n = imem_rdata;
              pc_n         = addr_inc;
              state_n      = HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall) begin
            valid_n    = 1'b1;
            ifpc_n     = skid_pc;
            instr_n    = skid_instr;
            skid_vld_n = 1'b0;
            addr_n     = pc;
            state_n    = REQ;
          end
        end
        default: state_n = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= RESET_PC;
      addr       <= RESET_PC;
      if_valid   <= 1'b0;
      if_pc      <= '0;
      if_instr   <= '0;
      skid_vld   <= 1'b0;
      skid_pc    <= '0;
      skid_instr <= '0;
      discard    <= 1'b0;
      fault      <= 1'b0;
      fault_pend <= 1'b0;
    end else begin
      pc         <= pc_n;
      addr       <= addr_n;
      if_valid   <= valid_n;
      if_pc      <= ifpc_n;
      if_instr   <= instr_n;
      skid_vld   <= skid_vld_n;
      skid_pc    <= skid_pc_n;
      skid_instr <= skid_instr_n;
      discard    <= discard_n;
      fault      <= fault_n;
      fault_pend <= fault_pend_n;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: cycle table for streams/stall/redirect, hand sequences for discard and fault.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        reset, stall, redirect, imem_ack;
  logic [63:0] redirect_pc;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [63:0] if_pc;
  logic [31:0] if_instr;
  logic        fetch_fault;

  int n_cmp = 0;
  int n_err = 0;

  fetch_unit #(.N(64), .RESET_PC(64'd0)) dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_pc(if_pc), .if_instr(if_instr), .fetch_fault(fetch_fault)
  );

  always #5 clk = ~clk;

  // Memory model: instruction word is a fixed function of its address.
  assign imem_rdata = imem_addr[31:0] ^ 32'hA5A5_0000;

  typedef struct {
    bit          rst, st, ak, rd;
    logic [63:0] rp;
    bit          ck, cp, ev, eq;
    logic [63:0] ep, ea;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(bit rst, bit st, bit ak, bit rd, logic [63:0] rp,
                              bit ck, bit cp, bit ev, bit eq, logic [63:0] ep, logic [63:0] ea);
    vec_t v;
    v.rst = rst; v.st = st; v.ak = ak; v.rd = rd; v.rp = rp;
    v.ck = ck; v.cp = cp; v.ev = ev; v.eq = eq; v.ep = ep; v.ea = ea;
    return v;
  endfunction

  task automatic cmp(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic cyc(bit rst, bit st, bit ak, bit rd, logic [63:0] rp);
    @(negedge clk);
    reset = rst; stall = st; imem_ack = ak; redirect = rd; redirect_pc = rp;
    @(posedge clk);
    #1;
  endtask

  logic [63:0] mis_rpc;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; imem_ack = 1'b0; redirect_pc = '0;
`ifdef FETCH_ALIGN_CHECK_EN
    mis_rpc = 64'h300;
`else
    mis_rpc = 64'h302;
`endif

    //           rst st ak rd rp         ck cp ev eq ep        ea
    // zero-wait stream, then stall with skid
    tv.push_back(mk(1, 0, 1, 0, 0,         0, 0, 0, 0, 0,        0));
    tv.push_back(mk(1, 0, 1, 0, 0,         1, 1, 0, 0, 0,        0));
    tv.push_back(mk(1, 0, 1, 0, 0,         0, 0, 0, 0, 0,        0));
    tv.push_back(mk(0, 0, 1, 0, 0,         1, 1, 0, 0, 0,        0));
    tv.push_back(mk(0, 0, 1, 0, 0,         1, 0, 0, 1, 0,        0));
    tv.push_back(mk(0, 0, 1, 0, 0,         1, 1, 1, 1, 0,        4));
    tv.push_back(mk(0, 0, 1, 0, 0,         1, 1, 1, 1, 4,        8));
    tv.push_back(mk(0, 1, 1, 0, 0,         1, 1, 1, 1, 8,        'hC));
    tv.push_back(mk(0, 1, 1, 0, 0,         1, 1, 1, 0, 8,        'hC));
    tv.push_back(mk(0, 1, 1, 0, 0,         1, 1, 1, 0, 8,        'hC));
    tv.push_back(mk(0, 0, 1, 0, 0,         1, 1, 1, 0, 8,        'hC));
    tv.push_back(mk(0, 0, 1, 0, 0,         1, 1, 1, 1, 'hC,      'h10));
    tv.push_back(mk(0, 0, 1, 0, 0,         1, 1, 1, 1, 'h10,     'h14));
    // two wait states per request
    tv.push_back(mk(1, 0, 0, 0, 0,         0, 0, 0, 0, 0,        0));
    tv.push_back(mk(1, 0, 0, 0, 0,         0, 0, 0, 0, 0,        0));
    tv.push_back(mk(0, 0, 0, 0, 0,         1, 1, 0, 0, 0,        0));
    tv.push_back(mk(0, 0, 0, 0, 0,         1, 0, 0, 1, 0,        0));
    tv.push_back(mk(0, 0, 0, 0, 0,         1, 0, 0, 1, 0,        0));
    tv.push_back(mk(0, 0, 1, 0, 0,         1, 0, 0, 1, 0,        0));
    tv.push_back(mk(0, 0, 0, 0, 0,         1, 1, 1, 1, 0,        4));
    tv.push_back(mk(0, 0, 0, 0, 0,         1, 0, 0, 1, 0,        4));
    tv.push_back(mk(0, 0, 1, 0, 0,         1, 0, 0, 1, 0,        4));
    tv.push_back(mk(0, 0, 0, 0, 0,         1, 1, 1, 1, 4,        8));
    tv.push_back(mk(0, 0, 0, 0, 0,         1, 0, 0, 1, 0,        8));
    tv.push_back(mk(0, 0, 1, 0, 0,         1, 0, 0, 1, 0,        8));
    tv.push_back(mk(0, 0, 0, 0, 0,         1, 1, 1, 1, 8,        'hC));
    tv.push_back(mk(0, 0, 0, 0, 0,         1, 0, 0, 1, 0,        'hC));
    tv.push_back(mk(0, 0, 1, 0, 0,         1, 0, 0, 1, 0,        'hC));
    tv.push_back(mk(0, 0, 0, 0, 0,         1, 1, 1, 1, 'hC,      'h10));
    // redirect while 0x10 is pending: its data must be dropped
    tv.push_back(mk(0, 0, 0, 1, 'h100,     1, 0, 0, 1, 0,        'h10));
    tv.push_back(mk(0, 0, 1, 0, 0,         1, 0, 0, 1, 0,        'h10));
    tv.push_back(mk(0, 0, 0, 0, 0,         1, 0, 0, 1, 0,        'h100));
    tv.push_back(mk(0, 0, 1, 0, 0,         1, 0, 0, 1, 0,        'h100));
    tv.push_back(mk(0, 0, 0, 0, 0,         1, 1, 1, 1, 'h100,    'h104));
    // redirect together with ack and stall
    tv.push_back(mk(0, 1, 1, 0, 0,         1, 0, 0, 1, 0,        'h104));
    tv.push_back(mk(0, 1, 1, 1, 'h200,     1, 1, 1, 1, 'h104,    'h108));
    tv.push_back(mk(0, 0, 1, 0, 0,         1, 0, 0, 1, 0,        'h200));
    tv.push_back(mk(0, 0, 1, 0, 0,         1, 1, 1, 1, 'h200,    'h204));
    // wrap at the top of the address space, then low-bit masking
    tv.push_back(mk(0, 0, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 1, 1, 1, 1, 'h204, 'h208));
    tv.push_back(mk(0, 0, 1, 0, 0,         1, 0, 0, 1, 0,        64'hFFFF_FFFF_FFFF_FFFC));
    tv.push_back(mk(0, 0, 1, 0, 0,         1, 1, 1, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0));
    tv.push_back(mk(0, 0, 1, 0, 0,         1, 1, 1, 1, 0,        4));
    tv.push_back(mk(0, 0, 1, 1, mis_rpc,   1, 1, 1, 1, 4,        8));
    tv.push_back(mk(0, 0, 1, 0, 0,         1, 0, 0, 1, 0,        'h300));
    tv.push_back(mk(0, 0, 1, 0, 0,         1, 1, 1, 1, 'h300,    'h304));
    // reset mid-stream with ack high
    tv.push_back(mk(1, 0, 1, 0, 0,         1, 1, 1, 1, 'h304,    'h308));
    tv.push_back(mk(0, 0, 1, 0, 0,         1, 1, 0, 0, 0,        0));
    tv.push_back(mk(0, 0, 1, 0, 0,         1, 0, 0, 1, 0,        0));

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      reset = tv[i].rst; stall = tv[i].st; imem_ack = tv[i].ak;
      redirect = tv[i].rd; redirect_pc = tv[i].rp;
      #1;
      if (tv[i].ck) begin
        cmp($sformatf("row%0d req", i),   {63'd0, imem_req},    {63'd0, tv[i].eq});
        cmp($sformatf("row%0d addr", i),  imem_addr,            tv[i].ea);
        cmp($sformatf("row%0d valid", i), {63'd0, if_valid},    {63'd0, tv[i].ev});
        cmp($sformatf("row%0d fault", i), {63'd0, fetch_fault}, 64'd0);
        if (tv[i].cp) begin
          cmp($sformatf("row%0d pc", i), if_pc, tv[i].ep);
          cmp($sformatf("row%0d instr", i), {32'd0, if_instr},
              tv[i].ev ? {32'd0, tv[i].ep[31:0] ^ 32'hA5A5_0000} : 64'd0);
        end
      end
    end

    // Two redirects during one wait, then redirect out of HOLD under stall.
    cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cmp("d0 req", {63'd0, imem_req}, 64'd1);
    cyc(0, 0, 0, 1, 'h40);
    cmp("d1 addr", imem_addr, 0);
    cyc(0, 0, 0, 1, 'h80);
    cmp("d2 addr", imem_addr, 0);
    cyc(0, 0, 1, 0, 0);
    cmp("d3 addr", imem_addr, 'h80);
    cmp("d3 valid", {63'd0, if_valid}, 0);
    cyc(0, 0, 1, 0, 0);
    cmp("d4 valid", {63'd0, if_valid}, 1);
    cmp("d4 pc", if_pc, 'h80);
    cmp("d4 instr", {32'd0, if_instr}, {32'd0, 32'h80 ^ 32'hA5A5_0000});
    cyc(0, 1, 1, 0, 0);
    cmp("d5 req", {63'd0, imem_req}, 0);
    cmp("d5 pc", if_pc, 'h80);
    cyc(0, 1, 1, 1, 'h500);
    cmp("d6 valid", {63'd0, if_valid}, 0);
    cmp("d6 addr", imem_addr, 'h500);
    cyc(0, 0, 1, 0, 0);
    cmp("d7 pc", if_pc, 'h500);
    cyc(0, 0, 1, 0, 0);
    cmp("d8 pc", if_pc, 'h504);

`ifdef FETCH_ALIGN_CHECK_EN
    // Misaligned redirect while a request waits: finish it, then park in FAULT.
    cyc(1, 0, 0, 0, 0); cyc(1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 'h102);
    cmp("f0 fault", {63'd0, fetch_fault}, 1);
    cyc(0, 0, 1, 0, 0);
    for (int k = 0; k < 3; k++) begin
      cmp($sformatf("f%0d req", k + 1), {63'd0, imem_req}, 0);
      cmp($sformatf("f%0d valid", k + 1), {63'd0, if_valid}, 0);
      cmp($sformatf("f%0d fault", k + 1), {63'd0, fetch_fault}, 1);
      cyc(0, 0, 1, 1, 'h200);
    end
    cyc(1, 0, 0, 0, 0);
    cmp("f4 fault", {63'd0, fetch_fault}, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
